// File: rtl/dct_pkg.sv
// Shared types and constants for the DCT coefficient lanes.
// The default widths here are the ones used by the standard 8x8 8-bit pipeline.
package dct_pkg;
   localparam int BLOCK_DIM     = 8;
   localparam int BLOCK_SAMPLES = 64;
   localparam int COS_FRAC_BITS = 8;
   localparam int PIX_OFFSET    = 128;

   localparam int PIX_W_D = 8;
   localparam int COS_W_D = 32;
   localparam int ACC_W_D = 32;
   localparam int OUT_W_D = 16;
   localparam int SHIFT_D = COS_FRAC_BITS + 2;

   typedef logic        [PIX_W_D-1:0] pix_t;
   typedef logic signed [COS_W_D-1:0] cos_t;
   typedef logic signed [ACC_W_D-1:0] acc_t;
   typedef logic signed [OUT_W_D-1:0] coeff_t;

   typedef enum logic {
      ACCUM,
      OUT
   } dct_acc_state_e;
endpackage

// File: rtl/dct_coeff_accumulator_if.sv
// Pixel stream, LUT index/term and coefficient handshake of one lane.
// master is the surrounding pipeline, slave is the accumulator.
interface dct_coeff_accumulator_if
   import dct_pkg::*;
#(
   parameter int PIX_W = PIX_W_D,
   parameter int COS_W = COS_W_D,
   parameter int OUT_W = OUT_W_D
);
   logic                    pix_valid;
   logic                    pix_ready;
   logic                    pix_sof;
   logic        [PIX_W-1:0] pix_data;
   logic        [2:0]       n1;
   logic        [2:0]       n2;
   logic signed [COS_W-1:0] cos_term;
   logic                    coeff_valid;
   logic                    coeff_ready;
   logic signed [OUT_W-1:0] coeff;
   logic                    sof_err;

   modport master (
      output pix_valid, pix_sof, pix_data, cos_term, coeff_ready,
      input  pix_ready, n1, n2, coeff_valid, coeff, sof_err
   );

   modport slave (
      input  pix_valid, pix_sof, pix_data, cos_term, coeff_ready,
      output pix_ready, n1, n2, coeff_valid, coeff, sof_err
   );
endinterface

// File: rtl/dct_round_sat.sv
// Round half toward +inf, arithmetic right shift, saturate to OUT_W.
// One extra guard bit keeps the rounding add from overflowing.
module dct_round_sat
   import dct_pkg::*;
#(
   parameter int ACC_W = ACC_W_D,
   parameter int SHIFT = SHIFT_D,
   parameter int OUT_W = OUT_W_D
)(
   input  logic signed [ACC_W-1:0] acc,
   output logic signed [OUT_W-1:0] coeff
);
   localparam int W = ACC_W + 1;
   localparam logic signed [W-1:0] RND =
      W'((longint'(1) <<< SHIFT) >>> 1);
   localparam logic signed [W-1:0] MAXV =
      W'((longint'(1) <<< (OUT_W - 1)) - 1);
   localparam logic signed [W-1:0] MINV = -MAXV - W'(1);

   logic signed [W-1:0] ext;
   logic signed [W-1:0] sum;
   logic signed [W-1:0] shr;

   assign ext = W'(acc);
   assign sum = ext + RND;
   assign shr = sum >>> SHIFT;

   always_comb begin
      coeff = OUT_W'(shr);
      if (shr > MAXV) begin
         coeff = OUT_W'(MAXV);
      end else if (shr < MINV) begin
         coeff = OUT_W'(MINV);
      end
   end
endmodule

// File: rtl/dct_coeff_accumulator.sv
// One DCT-II coefficient lane: sums (pixel-128)*cos_term over a raster
// 8x8 block and hands out one rounded, saturated coefficient.
module dct_coeff_accumulator
   import dct_pkg::*;
#(
   parameter int PIX_W = PIX_W_D,
   parameter int COS_W = COS_W_D,
   parameter int ACC_W = ACC_W_D,
   parameter int SHIFT = SHIFT_D,
   parameter int OUT_W = OUT_W_D
)(
   input logic clk,
   input logic rst,
   dct_coeff_accumulator_if.slave bus
);
   localparam int IDX_W  = $clog2(BLOCK_SAMPLES);
   localparam int DIM_W  = $clog2(BLOCK_DIM);
   localparam int PROD_W = PIX_W + 1 + COS_W;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BLOCK_SAMPLES - 1);
   localparam logic signed [PIX_W:0] OFFS = (PIX_W + 1)'(PIX_OFFSET);

   dct_acc_state_e state_q, state_d;

   logic        [IDX_W-1:0]  idx_q, idx_d, idx_lut;
   logic signed [ACC_W-1:0]  acc_q, acc_d, acc_base, acc_next, p;
   logic signed [OUT_W-1:0]  coeff_q, coeff_d, coeff_rs;
   logic signed [PIX_W:0]    d;
   logic signed [PROD_W-1:0] prod;
   logic                     sof_err_q;
   logic                     take, resync, last;

   assign take   = bus.pix_valid && (state_q == ACCUM);
   assign resync = take && bus.pix_sof && (idx_q != '0);
   assign last   = take && !resync && (idx_q == LAST_IDX);

   // A resyncing SOF beat must fetch the (0,0) term in its own cycle.
   assign idx_lut = resync ? '0 : idx_q;
   assign bus.n1  = idx_lut[IDX_W-1 -: DIM_W];
   assign bus.n2  = idx_lut[DIM_W-1:0];

   assign d        = $signed({1'b0, bus.pix_data}) - OFFS;
   assign prod     = d * bus.cos_term;
   assign p        = ACC_W'(prod);
   assign acc_base = ((idx_q == '0) || resync) ? '0 : acc_q;
   assign acc_next = acc_base + p;

   dct_round_sat #(
      .ACC_W (ACC_W),
      .SHIFT (SHIFT),
      .OUT_W (OUT_W)
   ) u_round_sat (
      .acc   (acc_next),
      .coeff (coeff_rs)
   );

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      acc_d   = acc_q;
      coeff_d = coeff_q;
      unique case (state_q)
         ACCUM: begin
            if (take) begin
               acc_d = acc_next;
               idx_d = resync ? IDX_W'(1) : idx_q + IDX_W'(1);
               if (last) begin
                  state_d = OUT;
                  coeff_d = coeff_rs;
               end
            end
         end
         OUT: begin
            if (bus.coeff_ready) begin
               state_d = ACCUM;
            end
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ACCUM;
         idx_q     <= '0;
         acc_q     <= '0;
         coeff_q   <= '0;
         sof_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         acc_q     <= acc_d;
         coeff_q   <= coeff_d;
         sof_err_q <= resync;
      end
   end

   assign bus.pix_ready   = (state_q == ACCUM);
   assign bus.coeff_valid = (state_q == OUT);
   assign bus.coeff       = coeff_q;
   assign bus.sof_err     = sof_err_q;
endmodule

// File: tb/tb_dct_coeff_accumulator.sv
// Bench for dct_coeff_accumulator: vector table, directed corner cases,
// and random blocks against a sum-of-products reference.
module tb_dct_coeff_accumulator;
   import dct_pkg::*;

   typedef struct {
      int p0;
      int fill;
      int c;
      int exp;
   } vec_t;

   logic clk;
   logic rst;

   dct_coeff_accumulator_if #(.PIX_W(8), .COS_W(32), .OUT_W(16)) bus ();
   dct_coeff_accumulator_if #(.PIX_W(8), .COS_W(32), .OUT_W(16)) bus2 ();

   dct_coeff_accumulator #(
      .PIX_W(8), .COS_W(32), .ACC_W(32), .SHIFT(10), .OUT_W(16)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   dct_coeff_accumulator #(
      .PIX_W(8), .COS_W(32), .ACC_W(32), .SHIFT(0), .OUT_W(16)
   ) dut_sat (
      .clk (clk),
      .rst (rst),
      .bus (bus2)
   );

   pix_t  pix_blk[64];
   cos_t  lut[64];
   cos_t  lut2_c;
   int    got_q[$];
   int    sof_cnt;
   int    tests;
   int    fails;
   vec_t  vecs[10];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always_comb bus.cos_term = lut[{bus.n1, bus.n2}];
   always_comb bus2.cos_term = lut2_c;

   always @(negedge clk) begin
      if (!rst && bus.coeff_valid && bus.coeff_ready)
         got_q.push_back(int'(bus.coeff));
      if (bus.sof_err)
         sof_cnt++;
   end

   task automatic chk(input string name, input longint act,
                      input longint exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic longint fdiv(input longint a, input longint b);
      longint q;
      q = a / b;
      if ((a % b != 0) && (a < 0))
         q = q - 1;
      return q;
   endfunction

   // floor(sum/2^s + 1/2), then clamp to 16-bit signed
   function automatic int model(input int shift);
      longint s, den, r;
      s = 0;
      for (int i = 0; i < 64; i++)
         s += (longint'(pix_blk[i]) - 128) * longint'(lut[i]);
      den = longint'(1) <<< shift;
      r = fdiv(2 * s + den, 2 * den);
      if (r > 32767) r = 32767;
      if (r < -32768) r = -32768;
      return int'(r);
   endfunction

   task automatic send_beat(input pix_t p, input bit sof);
      int t;
      t = 0;
      bus.pix_valid = 1'b1;
      bus.pix_data  = p;
      bus.pix_sof   = sof;
      while (!bus.pix_ready && t < 300) begin
         @(posedge clk); #1;
         t++;
      end
      if (t >= 300) chk("beat_timeout", 0, 1);
      @(posedge clk); #1;
      bus.pix_valid = 1'b0;
      bus.pix_sof   = 1'b0;
   endtask

   task automatic run_block(input int gap_max);
      for (int i = 0; i < 64; i++) begin
         send_beat(pix_blk[i], i == 0);
         if (gap_max > 0)
            repeat ($urandom_range(0, gap_max)) begin
               @(posedge clk); #1;
            end
      end
   endtask

   task automatic expect_coeff(input string name, input int exp);
      int t;
      t = 0;
      while (got_q.size() == 0 && t < 300) begin
         @(posedge clk); #1;
         t++;
      end
      if (got_q.size() == 0) begin
         chk({name, "_timeout"}, 0, 1);
      end else begin
         chk(name, got_q.pop_front(), exp);
      end
   endtask

   task automatic fill_rand();
      for (int i = 0; i < 64; i++) begin
         pix_blk[i] = pix_t'($urandom_range(0, 255));
         lut[i] = cos_t'($signed($urandom_range(0, 512)) - 256);
      end
   endtask

   initial begin
      int sof0, e;
      tests = 0; fails = 0; sof_cnt = 0;
      vecs[0] = '{128, 128, 150, 0};
      vecs[1] = '{255, 128, 150, 19};
      vecs[2] = '{0,   128, 150, -19};
      vecs[3] = '{129, 129, 256, 16};
      vecs[4] = '{127, 127, 256, -16};
      vecs[5] = '{124, 128, 128, 0};
      vecs[6] = '{132, 128, 128, 1};
      vecs[7] = '{125, 128, 171, -1};
      vecs[8] = '{255, 255, 8000, 32767};
      vecs[9] = '{0,   0,   8000, -32768};

      rst = 1'b1;
      bus.pix_valid = 0; bus.pix_sof = 0; bus.pix_data = 0;
      bus.coeff_ready = 1'b1;
      bus2.pix_valid = 0; bus2.pix_sof = 0; bus2.pix_data = 0;
      bus2.coeff_ready = 1'b1;
      lut2_c = 0;
      for (int i = 0; i < 64; i++) begin
         lut[i] = 0; pix_blk[i] = 0;
      end
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_pix_ready", bus.pix_ready, 1);
      chk("rst_coeff_valid", bus.coeff_valid, 0);
      chk("rst_coeff", bus.coeff, 0);
      chk("rst_sof_err", bus.sof_err, 0);
      chk("rst_n1n2", {bus.n1, bus.n2}, 0);
      @(posedge clk); #1;
      rst = 1'b0;

      for (int v = 0; v < 10; v++) begin
         for (int i = 0; i < 64; i++) begin
            pix_blk[i] = pix_t'(i == 0 ? vecs[v].p0 : vecs[v].fill);
            lut[i] = cos_t'(vecs[v].c);
         end
         run_block(0);
         chk($sformatf("vec%0d_latency", v), bus.coeff_valid, 1);
         expect_coeff($sformatf("vec%0d_coeff", v), vecs[v].exp);
      end
      chk("vec_no_sof_err", sof_cnt, 0);

      // stall: coefficient must hold, pixels must not be consumed
      for (int i = 0; i < 64; i++) begin
         pix_blk[i] = pix_t'(i == 0 ? 255 : 128);
         lut[i] = 150;
      end
      bus.coeff_ready = 1'b0;
      run_block(0);
      bus.pix_valid = 1'b1;
      bus.pix_data  = 0;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         chk("stall_valid", bus.coeff_valid, 1);
         chk("stall_coeff", bus.coeff, 19);
         chk("stall_pix_ready", bus.pix_ready, 0);
         @(posedge clk); #1;
      end
      bus.pix_valid = 1'b0;
      bus.coeff_ready = 1'b1;
      expect_coeff("stall_release", 19);
      @(posedge clk); #1;
      chk("post_xfer_valid", bus.coeff_valid, 0);
      chk("post_xfer_ready", bus.pix_ready, 1);
      chk("post_xfer_idx", {bus.n1, bus.n2}, 0);
      run_block(0);
      expect_coeff("post_stall_block", 19);

      // SOF resync at beat 20
      fill_rand();
      for (int i = 0; i < 20; i++)
         send_beat(pix_t'($urandom_range(0, 255)), i == 0);
      sof0 = sof_cnt;
      chk("pre_sof_idx", {bus.n1, bus.n2}, 20);
      bus.pix_valid = 1'b1;
      bus.pix_sof   = 1'b1;
      bus.pix_data  = pix_blk[0];
      #1;
      chk("sof_idx_forced", {bus.n1, bus.n2}, 0);
      @(posedge clk); #1;
      bus.pix_valid = 1'b0;
      bus.pix_sof   = 1'b0;
      chk("sof_err_pulse", bus.sof_err, 1);
      chk("sof_no_early_coeff", got_q.size(), 0);
      for (int i = 1; i < 64; i++)
         send_beat(pix_blk[i], 1'b0);
      expect_coeff("sof_resync_coeff", model(10));
      chk("sof_err_count", sof_cnt - sof0, 1);

      // async reset mid-block at beat 40
      fill_rand();
      for (int i = 0; i < 40; i++)
         send_beat(pix_blk[i], i == 0);
      #2 rst = 1'b1;
      #1;
      chk("mid_rst_n1n2", {bus.n1, bus.n2}, 0);
      chk("mid_rst_pix_ready", bus.pix_ready, 1);
      chk("mid_rst_valid", bus.coeff_valid, 0);
      chk("mid_rst_coeff", bus.coeff, 0);
      chk("mid_rst_sof_err", bus.sof_err, 0);
      @(posedge clk); #1;
      rst = 1'b0;
      fill_rand();
      run_block(0);
      expect_coeff("after_rst_coeff", model(10));

      // async reset while holding a coefficient
      fill_rand();
      bus.coeff_ready = 1'b0;
      run_block(0);
      chk("out_before_rst", bus.coeff_valid, 1);
      #2 rst = 1'b1;
      #1;
      chk("out_rst_valid", bus.coeff_valid, 0);
      chk("out_rst_coeff", bus.coeff, 0);
      chk("out_rst_pix_ready", bus.pix_ready, 1);
      @(posedge clk); #1;
      rst = 1'b0;
      bus.coeff_ready = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      chk("out_rst_no_emit", got_q.size(), 0);

      // random blocks with input gaps and output stalls
      for (int b = 0; b < 6; b++) begin
         fill_rand();
         e = model(10);
         bus.coeff_ready = 1'b0;
         run_block(2);
         repeat ($urandom_range(0, 4)) begin
            @(posedge clk); #1;
         end
         bus.coeff_ready = 1'b1;
         expect_coeff($sformatf("rand%0d", b), e);
      end

      // saturation lane with SHIFT=0
      lut2_c = 1000;
      for (int s = 0; s < 2; s++) begin
         for (int i = 0; i < 64; i++) begin
            bus2.pix_valid = 1'b1;
            bus2.pix_sof   = (i == 0);
            bus2.pix_data  = (s == 0) ? 8'd255 : 8'd0;
            @(posedge clk); #1;
         end
         bus2.pix_valid = 1'b0;
         bus2.pix_sof   = 1'b0;
         chk($sformatf("sat%0d_valid", s), bus2.coeff_valid, 1);
         chk($sformatf("sat%0d_coeff", s), bus2.coeff,
             (s == 0) ? 32767 : -32768);
         @(posedge clk); #1;
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
